// File: rtl/chunked_seq_adder.sv
// chunked_seq_adder
//   Multi-cycle adder/subtractor. WIDTH-bit operands are summed CHUNK bits per
//   clock, with the carry held in a register between chunks. START is taken in
//   IDLE only; BUSY covers the accept edge through the DONE cycle; DONE pulses
//   for one cycle when F/E/V are updated.
// Ports:
//   CLK, RST_N     rising-edge clock, asynchronous active-low reset
//   START          request (sampled only while idle)
//   SUB            0: A+B+C, 1: A-B-C (C is borrow-in)
//   A, B, C        operands and carry/borrow in, captured on accept
//   BUSY, DONE     handshake status
//   F, E, V        result, raw MSB carry out, signed overflow (held until next DONE)
module chunked_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] F,
  output logic             E,
  output logic             V
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  if (WIDTH < 2) begin : g_chk_width
    $error("chunked_seq_adder: WIDTH must be at least 2");
  end
  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_chk_chunk
    $error("chunked_seq_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_opa;
  logic [WIDTH-1:0]  r_opb;
  logic [WIDTH-1:0]  r_res;
  logic [WIDTH-1:0]  w_res_next;
  logic              r_cy;
  logic [IW-1:0]     r_idx;
  logic [CHUNK-1:0]  w_ca;
  logic [CHUNK-1:0]  w_cb;
  logic [CHUNK:0]    w_sum;
  logic              w_cin_msb;
  logic              w_last;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_next = r_state;
    BUSY   = 1'b0;
    DONE   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (START) w_next = S_RUN;
      end
      S_RUN: begin
        BUSY = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        BUSY   = 1'b1;
        DONE   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operands shift right one chunk per RUN edge, so the active chunk is always
  // the low CHUNK bits; the partial result shifts in from the top and is fully
  // aligned after NCH edges. Equivalent to indexing slice k on edge k.
  assign w_last     = (r_idx == LAST);
  assign w_ca       = r_opa[CHUNK-1:0];
  assign w_cb       = r_opb[CHUNK-1:0];
  assign w_sum      = {1'b0, w_ca} + {1'b0, w_cb} + {{CHUNK{1'b0}}, r_cy};
  assign w_res_next = (r_res >> CHUNK) | (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
  // Carry into the MSB recovered from the MSB sum bit and its two inputs.
  assign w_cin_msb  = w_ca[CHUNK-1] ^ w_cb[CHUNK-1] ^ w_sum[CHUNK-1];

  // Datapath
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_opa <= '0;
      r_opb <= '0;
      r_res <= '0;
      r_cy  <= 1'b0;
      r_idx <= '0;
      F     <= '0;
      E     <= 1'b0;
      V     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_opa <= A;
            r_opb <= SUB ? ~B : B;
            r_cy  <= C ^ SUB;
            r_idx <= '0;
          end
        end
        S_RUN: begin
          r_opa <= r_opa >> CHUNK;
          r_opb <= r_opb >> CHUNK;
          r_cy  <= w_sum[CHUNK];
          r_res <= w_res_next;
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            F <= w_res_next;
            E <= w_sum[CHUNK];
            V <= w_cin_msb ^ w_sum[CHUNK];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb_chunked_seq_adder
//   Drives five adder instances (16/4 and 8 with chunk 1,2,4,8) from shared
//   operand inputs and per-instance START, and compares against an
//   integer-arithmetic reference model.
module tb_chunked_seq_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sub;
  logic        c;
  logic [15:0] a;
  logic [15:0] b;
  logic [4:0]  start;

  wire  [4:0]  busy;
  wire  [4:0]  done;
  wire  [4:0]  e;
  wire  [4:0]  v;
  wire  [15:0] f16;
  wire  [7:0]  f8_1, f8_2, f8_4, f8_8;
  logic [15:0] f [5];

  int W [5] = '{16, 8, 8, 8, 8};
  int N [5] = '{4, 8, 4, 2, 1};
  logic [15:0] lastf [5];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .CLK(clk), .RST_N(rst_n), .START(start[0]), .SUB(sub), .A(a), .B(b), .C(c),
    .BUSY(busy[0]), .DONE(done[0]), .F(f16), .E(e[0]), .V(v[0]));
  chunked_seq_adder #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
    .CLK(clk), .RST_N(rst_n), .START(start[1]), .SUB(sub), .A(a[7:0]), .B(b[7:0]), .C(c),
    .BUSY(busy[1]), .DONE(done[1]), .F(f8_1), .E(e[1]), .V(v[1]));
  chunked_seq_adder #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
    .CLK(clk), .RST_N(rst_n), .START(start[2]), .SUB(sub), .A(a[7:0]), .B(b[7:0]), .C(c),
    .BUSY(busy[2]), .DONE(done[2]), .F(f8_2), .E(e[2]), .V(v[2]));
  chunked_seq_adder #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
    .CLK(clk), .RST_N(rst_n), .START(start[3]), .SUB(sub), .A(a[7:0]), .B(b[7:0]), .C(c),
    .BUSY(busy[3]), .DONE(done[3]), .F(f8_4), .E(e[3]), .V(v[3]));
  chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
    .CLK(clk), .RST_N(rst_n), .START(start[4]), .SUB(sub), .A(a[7:0]), .B(b[7:0]), .C(c),
    .BUSY(busy[4]), .DONE(done[4]), .F(f8_8), .E(e[4]), .V(v[4]));

  always_comb begin
    f[0] = f16;
    f[1] = {8'h00, f8_1};
    f[2] = {8'h00, f8_2};
    f[3] = {8'h00, f8_4};
    f[4] = {8'h00, f8_8};
  end

  task automatic chk(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical values.
  function automatic void model(input int w, input logic [15:0] ta, input logic [15:0] tb_,
                                input logic tc, input logic tsub,
                                output logic [15:0] ef, output logic ee, output logic ev);
    longint m, ua, ub, sa, sb, ci, res, sres;
    m    = longint'(1) << w;
    ua   = longint'(ta) & (m - 1);
    ub   = longint'(tb_) & (m - 1);
    sa   = (ua >= m / 2) ? ua - m : ua;
    sb   = (ub >= m / 2) ? ub - m : ub;
    ci   = tc ? 1 : 0;
    if (!tsub) begin
      res  = ua + ub + ci;
      ee   = (res >= m);
      sres = sa + sb + ci;
    end else begin
      res  = ua - ub - ci;
      ee   = (res >= 0);
      sres = sa - sb - ci;
    end
    ef = 16'(res & (m - 1));
    ev = (sres >= m / 2) || (sres < -(m / 2));
  endfunction

  task automatic scramble();
    a   = 16'($urandom);
    b   = 16'($urandom);
    c   = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Entered and left at a negedge with the instance idle.
  task automatic do_op(input int s, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tc, input logic tsub);
    logic [15:0] ef;
    logic ee, ev;
    int   n;
    bit   got;
    model(W[s], ta, tb_, tc, tsub, ef, ee, ev);
    a = ta; b = tb_; c = tc; sub = tsub;
    start[s] = 1'b1;
    @(posedge clk); @(negedge clk);
    start[s] = 1'b0;
    chk("busy_after_accept", busy[s], 1);
    chk("done_after_accept", done[s], 0);
    scramble();
    n = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      @(posedge clk); @(negedge clk);
      n++;
      got = done[s];
      scramble();
      if (!got) chk("f_hold_run", f[s], lastf[s]);
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("latency", n, N[s]);
      chk("f", f[s], ef);
      chk("e", e[s], ee);
      chk("v", v[s], ev);
      chk("busy_in_done", busy[s], 1);
      lastf[s] = ef;
    end
    @(posedge clk); @(negedge clk);
    chk("done_width", done[s], 0);
    chk("busy_after_done", busy[s], 0);
  endtask

  initial begin
    logic [15:0] ef;
    logic ee, ev;
    rst_n = 1'b0;
    start = '0;
    a = '0; b = '0; c = 1'b0; sub = 1'b0;
    for (int s = 0; s < 5; s++) lastf[s] = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      chk("rst_busy", busy[s], 0);
      chk("rst_done", done[s], 0);
      chk("rst_f", f[s], 0);
      chk("rst_e", e[s], 0);
      chk("rst_v", v[s], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed add/sub cases on the 16-bit instance
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op(0, 16'h1234, 16'h0000, 1'b1, 1'b0);
    do_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1);
    chk("sub_f_const", f[0], 16'hFFFE);
    do_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1);
    chk("sub_v_const", v[0], 1);

    // Handshake: extra STARTs in cycles 1, 2, 4 and in the DONE cycle are ignored
    model(16, 16'h1234, 16'h4321, 1'b1, 1'b1, ef, ee, ev);
    a = 16'h1234; b = 16'h4321; c = 1'b1; sub = 1'b1;
    start[0] = 1'b1;
    @(posedge clk);
    for (int cy = 1; cy <= 6; cy++) begin
      @(negedge clk);
      start[0] = (cy == 1 || cy == 2 || cy == 4 || cy == 5);
      chk("hs_busy", busy[0], (cy <= 5) ? 1 : 0);
      chk("hs_done", done[0], (cy == 5) ? 1 : 0);
      if (cy < 5) chk("hs_f_hold", f[0], lastf[0]);
      if (cy == 5) begin
        chk("hs_f", f[0], ef);
        chk("hs_e", e[0], ee);
        chk("hs_v", v[0], ev);
      end
      scramble();
      @(posedge clk);
    end
    @(negedge clk);
    start[0] = 1'b0;
    chk("hs_idle_after", busy[0], 0);
    lastf[0] = ef;
    @(negedge clk);

    // Reset in the second RUN cycle aborts the operation
    do_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1);
    a = 16'h0F0F; b = 16'h0101; c = 1'b0; sub = 1'b0;
    start[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    start[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_f", f[0], 0);
    chk("abort_e", e[0], 0);
    chk("abort_v", v[0], 0);
    for (int s = 0; s < 5; s++) lastf[s] = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_done", done[0], 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_abort_no_done", done[0], 0);
    end
    do_op(0, 16'h1234, 16'h0000, 1'b1, 1'b0);

    // Random full-range operations at 16 bits
    for (int k = 0; k < 25; k++)
      do_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    // 8-bit sweep over the chunk sizes: corners then random points
    for (int s = 1; s < 5; s++) begin
      for (int k = 0; k < 4; k++) begin
        do_op(s, 16'd255, 16'd63, k[0], k[1]);
        do_op(s, 16'd200, 16'd0, k[0], k[1]);
      end
      for (int k = 0; k < 30; k++)
        do_op(s, 16'($urandom_range(255, 200)), 16'($urandom_range(63, 0)),
              1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
